// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared seven-segment constants and digit patterns
package sseg_pkg;

   localparam int        NUM_DIGITS = 4;
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [3:0] AN_OFF    = 4'hF;
   localparam logic [7:0] SEG_MINUS = 8'h7F;

   // Active-low {g,f,e,d,c,b,a,dp} pattern for a decimal digit; out-of-range values give minus
   function automatic logic [7:0] seg_digit(input logic [3:0] d);
      case (d)
         4'd0:    seg_digit = 8'h81;
         4'd1:    seg_digit = 8'hF3;
         4'd2:    seg_digit = 8'h49;
         4'd3:    seg_digit = 8'h61;
         4'd4:    seg_digit = 8'h33;
         4'd5:    seg_digit = 8'h25;
         4'd6:    seg_digit = 8'h05;
         4'd7:    seg_digit = 8'hF1;
         4'd8:    seg_digit = 8'h01;
         4'd9:    seg_digit = 8'h21;
         default: seg_digit = SEG_MINUS;
      endcase
   endfunction

endpackage

// File: rtl/sseg_refresh_timer.sv
// rtl/sseg_refresh_timer.sv - digit slot counter, digit index, PWM counter and phase decode
module sseg_refresh_timer #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] i_brightness,
   output logic [1:0] o_idx,
   output logic       o_active,
   output logic       o_pwm_on,
   output logic       o_frame_end
);

   localparam int             CW         = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0]  SLOT_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0]  BLANK_END  = CW'(BLANK_CYCLES);

   logic [CW-1:0] r_slot_cnt;
   logic [1:0]    r_idx;
   logic [2:0]    r_pwm_cnt;
   logic          w_slot_end;

   assign w_slot_end  = (r_slot_cnt == SLOT_LAST);
   assign o_idx       = r_idx;
   assign o_active    = (r_slot_cnt >= BLANK_END);
   assign o_pwm_on    = (r_pwm_cnt <= i_brightness);
   assign o_frame_end = w_slot_end && (r_idx == 2'd3);

   // Slot counter wraps each slot and advances the digit index; PWM restarts at 0 every active phase
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_slot_cnt <= '0;
         r_idx      <= 2'd0;
         r_pwm_cnt  <= 3'd0;
      end else begin
         if (w_slot_end) begin
            r_slot_cnt <= '0;
            r_idx      <= r_idx + 2'd1;
         end else begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
         end
         if (o_active) r_pwm_cnt <= r_pwm_cnt + 3'd1;
         else          r_pwm_cnt <= 3'd0;
      end
   end

endmodule

// File: rtl/sseg_scan_driver.sv
// rtl/sseg_scan_driver.sv - multiplexed four-digit seven-segment display driver
module sseg_scan_driver
   import sseg_pkg::*;
#(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] seg_word,
   input  logic        enable,
   input  logic [2:0]  brightness,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_sync
);

   logic [31:0] r_shadow;
   logic [1:0]  w_idx;
   logic        w_active;
   logic        w_pwm_on;
   logic        w_frame_end;
   logic        w_lit;
   logic [7:0]  w_byte;

   sseg_refresh_timer #(
      .REFRESH_DIV  (REFRESH_DIV),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_timer (
      .clk          (clk),
      .rst          (rst),
      .i_brightness (brightness),
      .o_idx        (w_idx),
      .o_active     (w_active),
      .o_pwm_on     (w_pwm_on),
      .o_frame_end  (w_frame_end)
   );

   assign w_lit  = enable && w_active && w_pwm_on;
   assign w_byte = r_shadow[{w_idx, 3'b000} +: 8];

   // Shadow word is only replaced at the frame boundary so a frame is never torn
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shadow   <= {NUM_DIGITS{SEG_BLANK}};
         frame_sync <= 1'b0;
      end else begin
         frame_sync <= w_frame_end;
         if (w_frame_end) r_shadow <= seg_word;
      end
   end

   // Registered pin drive: one anode at most, everything off when dark
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an  <= AN_OFF;
         seg <= SEG_BLANK[7:1];
         dp  <= 1'b1;
      end else if (w_lit) begin
         an  <= ~(4'b0001 << w_idx);
         seg <= w_byte[7:1];
         dp  <= w_byte[0];
      end else begin
         an  <= AN_OFF;
         seg <= SEG_BLANK[7:1];
         dp  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb/tb_sseg_scan_driver.sv - randomized self-checking bench against a cycle-count model
module tb_sseg_scan_driver;

   localparam int RD = 16;
   localparam int BC = 2;
   localparam int FRAME = 4 * RD;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] seg_word = 32'h0;
   logic        enable = 1'b1;
   logic [2:0]  brightness = 3'd7;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_sync;

   int n_checks = 0;
   int n_pass   = 0;

   int          n;          // edges since reset release == current state index
   logic [31:0] m_shadow;

   sseg_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
      .clk        (clk),
      .rst        (rst),
      .seg_word   (seg_word),
      .enable     (enable),
      .brightness (brightness),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame_sync (frame_sync)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (n=%0d)", tag, got, exp, n);
   endtask

   task automatic check_dark(input string tag);
      check({tag, "_an"}, 32'(an), 32'hF);
      check({tag, "_seg"}, 32'(seg), 32'h7F);
      check({tag, "_dp"}, 32'(dp), 32'h1);
      check({tag, "_fs"}, 32'(frame_sync), 32'h0);
   endtask

   // Advance one clock; expectations come from the slot/frame arithmetic of state n
   task automatic cycle();
      int          slot, idx, pwm;
      bit          lit, exp_fs;
      logic [7:0]  b;
      logic [3:0]  exp_an;
      logic [6:0]  exp_seg;
      logic        exp_dp;
      logic [31:0] word_in;
      slot = n % RD;
      idx  = (n / RD) % 4;
      lit  = 1'b0;
      if (enable && slot >= BC) begin
         pwm = (slot - BC) % 8;
         lit = (pwm <= int'(brightness));
      end
      b       = m_shadow[8*idx +: 8];
      exp_an  = lit ? ~(4'b0001 << idx) : 4'hF;
      exp_seg = lit ? b[7:1] : 7'h7F;
      exp_dp  = lit ? b[0] : 1'b1;
      exp_fs  = ((n % FRAME) == FRAME - 1);
      word_in = seg_word;
      @(posedge clk);
      #1;
      check("an", 32'(an), 32'(exp_an));
      check("seg", 32'(seg), 32'(exp_seg));
      check("dp", 32'(dp), 32'(exp_dp));
      check("frame_sync", 32'(frame_sync), 32'(exp_fs));
      check("one_anode", 32'($countones(~an) <= 1), 32'h1);
      if (exp_fs) m_shadow = word_in;
      n++;
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) cycle();
   endtask

   task automatic run_random(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         if ($urandom_range(0, 19) == 0) seg_word = $urandom;
         brightness = 3'($urandom_range(0, 7));
         enable     = ($urandom_range(0, 9) != 0);
         cycle();
      end
   endtask

   initial begin
      n        = 0;
      m_shadow = 32'hFFFF_FFFF;
      #3 rst = 1'b1;
      #1 check_dark("rst_async");
      @(posedge clk);
      #1 rst = 1'b0;

      // Known word, full brightness: first frame blank, second shows the word
      seg_word = 32'h81F3_4961; brightness = 3'd7; enable = 1'b1;
      run(100);
      // Mid-frame update must wait for the next frame boundary
      seg_word = 32'h0101_0101;
      run(92);
      // PWM duty levels
      brightness = 3'd0; run(FRAME);
      brightness = 3'd3; run(FRAME);
      // Forced dark for a full frame, then resume
      brightness = 3'd7; enable = 1'b0; run(FRAME);
      enable = 1'b1; seg_word = 32'h2125_3305; run(FRAME + 8);
      run_random(600);

      // Asynchronous reset during slot idx 2
      while (((n / RD) % 4) != 2) cycle();
      run(5);
      #2 rst = 1'b1;
      #1 check_dark("rst_mid");
      @(posedge clk);
      #1 rst = 1'b0;
      n        = 0;
      m_shadow = 32'hFFFF_FFFF;
      seg_word = 32'h81F3_4961; brightness = 3'd7; enable = 1'b1;
      run(FRAME + 20);
      run_random(300);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
